// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: synchronised SCK/SS_N/MOSI, one-deep TX holding register,
// RX valid/ack handshake with sticky overrun and TX underrun pulse.
module spi_slave_if #(
    parameter int unsigned                DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = {DATA_WIDTH{1'b1}}
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sck,
    input  logic                  i_ss_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_load,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ack,
    output logic                  o_rx_overrun,
    output logic                  o_tx_underrun
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_t;

    logic [1:0]            r_sck_sync;
    logic                  r_sck_hist;
    logic [1:0]            r_ss_sync;
    logic                  r_ss_hist;
    logic [1:0]            r_mosi_sync;

    state_t                r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic                  r_miso_oe;
    logic [DATA_WIDTH-1:0] r_tx_hold;
    logic                  r_tx_ready;
    logic                  r_tx_underrun;
    logic                  r_rx_done;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_rx_overrun;

    logic                  w_sck_rise;
    logic                  w_sck_fall;
    logic                  w_ss_fall;
    logic                  w_ss_rise;
    logic                  w_reload;
    logic [DATA_WIDTH-1:0] w_load_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_sync  <= 2'b00;
            r_sck_hist  <= 1'b0;
            r_ss_sync   <= 2'b11;
            r_ss_hist   <= 1'b1;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sck_sync  <= {r_sck_sync[0], i_sck};
            r_sck_hist  <= r_sck_sync[1];
            r_ss_sync   <= {r_ss_sync[0], i_ss_n};
            r_ss_hist   <= r_ss_sync[1];
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
        end
    end

    always_comb begin
        w_sck_rise  = r_sck_sync[1] & ~r_sck_hist;
        w_sck_fall  = ~r_sck_sync[1] & r_sck_hist;
        w_ss_fall   = ~r_ss_sync[1] & r_ss_hist;
        w_ss_rise   = r_ss_sync[1] & ~r_ss_hist;
        w_load_word = r_tx_ready ? IDLE_FILL : r_tx_hold;
        // Frame start, or the first SCK fall after a completed word with SS_N still low
        w_reload    = ((r_state == StIdle) && w_ss_fall) ||
                      ((r_state == StShift) && !w_ss_rise && w_sck_fall &&
                       (r_bit_cnt == CNT_FULL));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_bit_cnt     <= '0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_miso_oe     <= 1'b0;
            r_tx_hold     <= '0;
            r_tx_ready    <= 1'b1;
            r_tx_underrun <= 1'b0;
            r_rx_done     <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_overrun  <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            r_rx_done     <= 1'b0;

            // A reload with TX empty leaves tx_ready=1, so a coincident load still lands
            if (w_reload && !r_tx_ready) begin
                r_tx_ready <= 1'b1;
            end else if (i_tx_load && r_tx_ready) begin
                r_tx_hold  <= i_tx_data;
                r_tx_ready <= 1'b0;
            end

            if (w_reload) begin
                r_tx_shift    <= w_load_word;
                r_bit_cnt     <= '0;
                r_tx_underrun <= r_tx_ready;
            end

            case (r_state)
                StIdle: begin
                    if (w_ss_fall) begin
                        r_state   <= StShift;
                        r_miso_oe <= 1'b1;
                    end
                end
                StShift: begin
                    if (w_ss_rise) begin
                        r_state    <= StIdle;
                        r_miso_oe  <= 1'b0;
                        r_tx_shift <= '0;
                        r_bit_cnt  <= '0;
                    end else if (w_sck_rise && (r_bit_cnt != CNT_FULL)) begin
                        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync[1]};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_rx_done  <= (r_bit_cnt == CNT_LAST);
                    end else if (w_sck_fall && (r_bit_cnt != '0) && (r_bit_cnt != CNT_FULL)) begin
                        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            endcase

            // Completion beats a coincident ack
            if (r_rx_done) begin
                r_rx_data    <= r_rx_shift;
                r_rx_valid   <= 1'b1;
                r_rx_overrun <= r_rx_valid & ~i_rx_ack;
            end else if (i_rx_ack) begin
                r_rx_valid   <= 1'b0;
                r_rx_overrun <= 1'b0;
            end
        end
    end

    assign o_miso        = r_tx_shift[DATA_WIDTH-1];
    assign o_miso_oe     = r_miso_oe;
    assign o_tx_ready    = r_tx_ready;
    assign o_tx_underrun = r_tx_underrun;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: acts as SPI master, keeps a transaction-level model of the
// TX holding register and RX handshake, and checks the DUT against it.
module tb_spi_slave_if;

    localparam int W = 8;
    localparam logic [7:0] FILL = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_load = 1'b0;
    logic       rx_ack = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun;
    logic [7:0] rx_data;

    spi_slave_if #(.DATA_WIDTH(8), .IDLE_FILL(8'hFF)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sck        (sck),
        .i_ss_n       (ss_n),
        .i_mosi       (mosi),
        .o_miso       (miso),
        .o_miso_oe    (miso_oe),
        .i_tx_data    (tx_data),
        .i_tx_load    (tx_load),
        .o_tx_ready   (tx_ready),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .i_rx_ack     (rx_ack),
        .o_rx_overrun (rx_overrun),
        .o_tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Transaction-level model
    bit         m_full = 0;
    logic [7:0] m_hold = '0;
    bit         m_rxv = 0;
    bit         m_ovr = 0;
    logic [7:0] m_rxd = '0;
    int         m_und = 0;
    int         und_seen = 0;

    bit         chk_on = 0;
    bit         settled = 0;
    bit         in_frame = 0;
    logic [7:0] frm_q[$];
    logic [7:0] got_miso[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reload(output logic [7:0] w);
        if (m_full) begin
            w = m_hold;
            m_full = 0;
        end else begin
            w = FILL;
            m_und++;
        end
    endtask

    task automatic model_load(input logic [7:0] d);
        if (!m_full) begin
            m_full = 1;
            m_hold = d;
        end
    endtask

    task automatic model_rx(input logic [7:0] d, input bit ack_coll);
        m_ovr = ack_coll ? 1'b0 : (m_ovr | m_rxv);
        m_rxv = 1;
        m_rxd = d;
    endtask

    task automatic do_load(input logic [7:0] d);
        settled = 0;
        tx_data = d;
        tx_load = 1'b1;
        model_load(d);
        tick(1);
        tx_load = 1'b0;
        tick(1);
        settled = 1;
    endtask

    task automatic do_ack();
        settled = 0;
        rx_ack = 1'b1;
        m_rxv = 0;
        m_ovr = 0;
        tick(1);
        rx_ack = 1'b0;
        tick(1);
        settled = 1;
    endtask

    // One SS_N-low burst carrying frm_q; the last frame may be cut short after last_bits.
    task automatic burst(input int half, input int last_bits, input int ld_frame,
                         input logic [7:0] ld_val, input bit ack_last);
        logic [7:0] w, rx, smp;
        int nb;
        settled = 0;
        ss_n = 1'b0;
        model_reload(w);
        tick(3);
        chk("tx_ready_at_start", tx_ready, !m_full);
        chk("miso_oe_on", miso_oe, 1);
        in_frame = 1;
        settled = 1;
        for (int f = 0; f < frm_q.size(); f++) begin
            nb = (f == frm_q.size() - 1) ? last_bits : W;
            rx = '0;
            smp = '0;
            for (int b = 0; b < nb; b++) begin
                mosi = frm_q[f][7-b];
                rx = {rx[6:0], mosi};
                if (f == ld_frame && b == 3) begin
                    tx_data = ld_val;
                    tx_load = 1'b1;
                    model_load(ld_val);
                    tick(1);
                    tx_load = 1'b0;
                    tick(half - 1);
                end else begin
                    tick(half);
                end
                sck = 1'b1;
                if (b == W - 1 && f == frm_q.size() - 1 && half >= 5) begin
                    tick(3);
                    if (ack_last) rx_ack = 1'b1;
                    tick(1);
                    rx_ack = 1'b0;
                    model_rx(rx, ack_last);
                    chk("rx_valid_latency", rx_valid, 1);
                    chk("rx_overrun_latency", rx_overrun, m_ovr);
                    chk("rx_data_latency", rx_data, m_rxd);
                    tick(half - 4);
                end else begin
                    tick(half);
                    if (b == W - 1) model_rx(rx, 1'b0);
                end
                smp = {smp[6:0], miso};
                chk("miso_bit", miso, w[7-b]);
                sck = 1'b0;
            end
            if (nb == W) begin
                got_miso.push_back(smp);
                model_reload(w);
            end
        end
        tick(half);
        settled = 0;
        in_frame = 0;
        ss_n = 1'b1;
        tick(3);
        chk("miso_oe_off_3clk", miso_oe, 0);
        chk("miso_low_idle", miso, 0);
        tick(1);
        chk("underrun_count", und_seen, m_und);
        settled = 1;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) und_seen += int'(tx_underrun);
        if (chk_on && settled) begin
            if (in_frame) begin
                chk("miso_oe_selected", miso_oe, 1);
            end else begin
                chk("miso_oe_idle", miso_oe, 0);
                chk("miso_idle", miso, 0);
                chk("tx_underrun_idle", tx_underrun, 0);
                chk("tx_ready", tx_ready, !m_full);
                chk("rx_valid", rx_valid, m_rxv);
                chk("rx_overrun", rx_overrun, m_ovr);
                if (m_rxv) chk("rx_data", rx_data, m_rxd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        int half, n, lb, frames, u0;

        // Reset values
        tick(3);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_overrun", rx_overrun, 0);
        chk("rst_tx_underrun", tx_underrun, 0);
        rst_n = 1'b1;
        tick(2);
        chk_on = 1;
        settled = 1;

        // Reset asserted mid-frame at bit 4
        do_load(8'h00);
        do_ack();
        settled = 0;
        ss_n = 1'b0;
        model_reload(w);
        tick(3);
        in_frame = 1;
        for (int b = 0; b < 4; b++) begin
            mosi = 1'($urandom);
            tick(3);
            sck = 1'b1;
            tick(3);
            chk("pre_reset_miso", miso, w[7-b]);
            sck = 1'b0;
        end
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_miso", miso, 0);
        chk("midrst_miso_oe", miso_oe, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_rx_data", rx_data, 8'h00);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_rx_overrun", rx_overrun, 0);
        chk("midrst_tx_underrun", tx_underrun, 0);
        m_full = 0;
        m_rxv = 0;
        m_ovr = 0;
        m_rxd = '0;
        in_frame = 0;
        ss_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        settled = 1;

        // Empty TX after reset: 0xFF plus underrun
        u0 = und_seen;
        frm_q.delete();
        frm_q.push_back(8'h5A);
        burst(2, 8, -1, 8'h00, 0);
        chk("after_reset_miso", got_miso[got_miso.size()-1], 8'hFF);
        chk("after_reset_underruns", und_seen - u0, 2);

        // Single frame
        do_ack();
        do_load(8'hA5);
        frm_q.delete();
        frm_q.push_back(8'h3C);
        burst(5, 8, -1, 8'h00, 0);
        chk("single_miso", got_miso[got_miso.size()-1], 8'hA5);
        chk("single_rx_data", rx_data, 8'h3C);
        chk("single_rx_valid", rx_valid, 1);

        // Back-to-back frames, second TX word loaded during the first
        do_ack();
        do_load(8'h11);
        frm_q.delete();
        frm_q.push_back(8'h81);
        frm_q.push_back(8'h7E);
        burst(2, 8, 0, 8'h22, 0);
        chk("b2b_miso0", got_miso[got_miso.size()-2], 8'h11);
        chk("b2b_miso1", got_miso[got_miso.size()-1], 8'h22);
        chk("b2b_rx_data", rx_data, 8'h7E);
        chk("b2b_overrun", rx_overrun, 1);

        // Abort after 5 bits, then empty-TX frame
        do_ack();
        frm_q.delete();
        frm_q.push_back(8'hF0);
        burst(3, 5, -1, 8'h00, 0);
        chk("abort_rx_valid", rx_valid, 0);
        u0 = und_seen;
        frm_q.delete();
        frm_q.push_back(8'h96);
        burst(3, 8, -1, 8'h00, 0);
        chk("abort_next_miso", got_miso[got_miso.size()-1], 8'hFF);
        chk("abort_next_underruns", und_seen - u0, 2);

        // Ignored load while full; ack colliding with completion
        do_ack();
        do_load(8'h5A);
        do_load(8'hC3);
        chk("tx_ready_full", tx_ready, 0);
        frm_q.delete();
        frm_q.push_back(8'h12);
        burst(5, 8, -1, 8'h00, 0);
        chk("ignored_load_miso", got_miso[got_miso.size()-1], 8'h5A);
        frm_q.delete();
        frm_q.push_back(8'h34);
        burst(5, 8, -1, 8'h00, 1);
        chk("collide_rx_valid", rx_valid, 1);
        chk("collide_overrun", rx_overrun, 0);
        chk("collide_rx_data", rx_data, 8'h34);

        // Random regression
        frames = 0;
        while (frames < 500) begin
            half = (frames < 250) ? 2 : 5;
            repeat ($urandom_range(1, 4)) begin
                case ($urandom_range(0, 3))
                    0: do_load(8'($urandom));
                    1: do_ack();
                    default: tick($urandom_range(1, 6));
                endcase
            end
            n = $urandom_range(1, 3);
            lb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 8;
            frm_q.delete();
            for (int i = 0; i < n; i++) frm_q.push_back(8'($urandom));
            burst(half, lb, (n > 1 && $urandom_range(0, 1) == 1) ? 0 : -1, 8'($urandom),
                  (half == 5) && ($urandom_range(0, 3) == 0));
            frames += n;
        end
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI responder (mode 0, CPOL=0/CPHA=0, MSB first) for the far end of the SoC's SPI master link, so a J1-side peripheral can be a target for an external or loop-back master.
- Oversamples SCK, SS_N and MOSI in the `clk` domain through synchronizers.
- Shifts out a byte taken from a one-deep TX holding register.
- Delivers received bytes through a valid/ack handshake with a sticky overrun flag.
- Designed to be wrapped by a memory-mapped peripheral shell on the J1 IO bus.

Parameters:
- DATA_WIDTH, 8, frame length in bits and width of the TX/RX data ports.
- IDLE_FILL, 8'hFF, word shifted out when no TX data is loaded at frame start (DATA_WIDTH bits).

Ports:
- clk  input  1  system clock; must be at least 4x the SCK frequency.
- rst  input  1  asynchronous active-low reset.
- sck  input  1  SPI clock from master (asynchronous).
- ss_n  input  1  active-low slave select from master (asynchronous).
- mosi  input  1  serial data from master (asynchronous).
- miso  output  1  serial data to master.
- miso_oe  output  1  MISO output enable; 1 only while selected.
- tx_data  input  DATA_WIDTH  word to transmit in the next frame.
- tx_load  input  1  write strobe for tx_data; honoured only when tx_ready=1.
- tx_ready  output  1  TX holding register empty.
- rx_data  output  DATA_WIDTH  last complete received word.
- rx_valid  output  1  rx_data holds an unacknowledged word.
- rx_ack  input  1  consumer acknowledge; clears rx_valid and rx_overrun.
- rx_overrun  output  1  sticky: a word completed while rx_valid=1.
- tx_underrun  output  1  one-cycle pulse when a frame starts with TX empty.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, tx_underrun=0.
  - FSM=IDLE, bit counter=0, shift register=0.
  - All synchronizer flops to idle: sck=0, ss_n=1.
- Synchronizers: 2 flops per input, plus one history flop each on sck and ss_n for edge detection. A pin edge is seen as a detected edge on the 3rd clk rising edge after it.
- FSM states IDLE, SHIFT:
  - IDLE→SHIFT on detected ss_n fall.
    - If TX is full: shift register loaded from the holding register and tx_ready←1.
    - If TX is empty: shift register loaded with IDLE_FILL and tx_underrun pulses.
    - Bit counter←0, miso_oe←1, miso←MSB of the loaded word, all in the same cycle.
  - SHIFT, detected sck rise: sample the synchronized mosi into the shift LSB side (capture register); counter+1.
  - SHIFT, detected sck fall: shift left; miso←new MSB.
  - Frame complete: on the DATA_WIDTH-th sck rise, the captured word→rx_data in the next cycle.
    - If rx_valid was already 1, rx_overrun←1 and rx_data is overwritten with the new word.
    - rx_valid←1 in all cases.
  - Back-to-back frames with ss_n held low: on the sck fall following a completed frame, reload TX exactly as at frame start (including the underrun rule) and restart the count.
  - SHIFT→IDLE on detected ss_n rise in any bit position: miso_oe←0, miso←0, counter←0.
    - A partial word is discarded; rx_valid is not affected.
    - A consumed TX word is not re-sent.
- TX handshake:
  - tx_load while tx_ready=1 → holding←tx_data, tx_ready←0 next cycle.
  - tx_load while tx_ready=0 is ignored.
  - tx_load in the same cycle as a frame-start reload (tx_ready=1): the reload takes IDLE_FILL, then the new word is stored for the next frame.
- RX handshake: rx_ack clears rx_valid and rx_overrun next cycle. If rx_ack coincides with a frame completion, the completion wins: rx_valid=1, rx_overrun=0.
- sck edges while in IDLE are ignored.
- SPI timing:
  - miso changes ≤4 clk after the pin SCK fall.
  - Minimum SCK high/low time is 2 clk periods.

Test Plan:
- Reset then idle: hold rst=0 mid-frame at bit 4 → all outputs at reset values; after release, ss_n low with no tx_load → tx_underrun pulse, MISO shifts 0xFF.
- Single frame: tx_load 0xA5; master sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1 ≤4 clk after the 8th SCK rise; tx_ready=1 right after ss_n fall detect.
- Back-to-back frames: load 0x11, ss_n low, 16 SCK cycles, load 0x22 during the first frame → MISO 0x11 then 0x22; master bytes 0x81 then 0x7E; no rx_ack → rx_data=0x7E, rx_overrun=1.
- Abort: ss_n rises after 5 bits of 0xF0 → no rx_valid, miso_oe=0 within 3 clk; the next frame with empty TX sends 0xFF plus tx_underrun.
- Handshake collision: rx_ack asserted in the completion cycle of a second frame → rx_valid=1, rx_overrun=0; tx_load while tx_ready=0 does not change the next transmitted word.
- Random regression: 500 random frames at SCK = clk/4 and clk/10 with random ss_n gaps → scoreboard matches MOSI→rx_data and TX→MISO.
